// File: rtl/dma_sample_packer.sv
// Decimating sample packer: packs PDH loop samples into 64-bit words, buffers them in a
// first-word-fall-through FIFO and frames a fixed-length capture for the DMA write path.
module dma_sample_packer #(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int DAC_DATA_WIDTH = 14,
    parameter int FIFO_DEPTH     = 16,
    parameter int DECIM_WIDTH    = 16,
    parameter int LEN_WIDTH      = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [DECIM_WIDTH-1:0]    decim_i,
    input  logic [LEN_WIDTH-1:0]      frame_len_i,
    input  logic [ADC_DATA_WIDTH-1:0] adc_a_i,
    input  logic [ADC_DATA_WIDTH-1:0] adc_b_i,
    input  logic [DAC_DATA_WIDTH-1:0] dac_i,
    input  logic [15:0]               err_i,
    output logic [63:0]               data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overflow_o,
    output logic [LEN_WIDTH-1:0]      words_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic                   enable_prev_reg;
    logic [DECIM_WIDTH-1:0] decim_reg;
    logic [DECIM_WIDTH-1:0] dec_cnt_reg;
    logic [LEN_WIDTH-1:0]   len_reg;
    logic [LEN_WIDTH-1:0]   words_reg;
    logic                   overflow_reg;

    logic [63:0]            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [PTR_W:0]         count_reg;

    logic        arm;
    logic        strobe;
    logic        pop;
    logic        room;
    logic        push;
    logic        drop;
    logic        flush;
    logic [63:0] packed_word;

    assign packed_word = {err_i, 16'($signed(dac_i)), 16'($signed(adc_b_i)), 16'($signed(adc_a_i))};

    assign arm    = enable_i && !enable_prev_reg;
    assign strobe = (dec_cnt_reg == '0);
    assign pop    = valid_o && ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign room   = (count_reg != FULL_COUNT) || pop;

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        drop       = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arm) begin
                    state_next = (frame_len_i == '0) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!enable_i) begin
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end else if (strobe) begin
                    if (room) begin
                        push = 1'b1;
                        if (words_reg + 1'b1 == len_reg) begin
                            state_next = ST_DRAIN;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!enable_i) begin
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end else if (count_reg == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!enable_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            enable_prev_reg <= 1'b0;
            decim_reg       <= '0;
            dec_cnt_reg     <= '0;
            len_reg         <= '0;
            words_reg       <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            enable_prev_reg <= enable_i;
            if (state_reg == ST_IDLE && arm) begin
                decim_reg    <= decim_i;
                len_reg      <= frame_len_i;
                words_reg    <= '0;
                overflow_reg <= 1'b0;
                dec_cnt_reg  <= '0;
            end else if (state_reg == ST_CAPTURE) begin
                // Compare before incrementing so an all-ones setting wraps to 0 exactly once.
                dec_cnt_reg <= (dec_cnt_reg == decim_reg) ? '0 : dec_cnt_reg + 1'b1;
            end
            if (push) begin
                words_reg <= words_reg + 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= packed_word;
        end
    end

    assign valid_o    = (count_reg != '0);
    assign data_o     = valid_o ? mem[rd_ptr_reg] : 64'd0;
    assign busy_o     = (state_reg == ST_CAPTURE) || (state_reg == ST_DRAIN);
    assign done_o     = (state_reg == ST_DONE);
    assign overflow_o = overflow_reg;
    assign words_o    = words_reg;

endmodule

// File: doc/dma_sample_packer.md
Name: dma_sample_packer

Overview:
- Capture front-end feeding the HP0 DMA write path, clocked in the pdh_core ADC clock domain.
- Decimates per-cycle PDH loop samples (ADC A, ADC B, DAC output, error signal) and packs each kept sample into one 64-bit word.
- Buffers words in a small FIFO and presents them on a valid/ready stream to the DMA data input.
- Frames a fixed-length capture: arm, fill N words, drain, report done or overflow.

Parameters:
- ADC_DATA_WIDTH, 14, width of signed ADC samples
- DAC_DATA_WIDTH, 14, width of signed DAC samples
- FIFO_DEPTH, 16, word buffer depth; power of two, at least 2
- DECIM_WIDTH, 16, width of decimation setting
- LEN_WIDTH, 20, width of frame length and word counter

Ports:
- clk  in  1  ADC clock
- rst_n  in  1  reset
- enable_i  in  1  arm/hold capture; deassert to abort or acknowledge done
- decim_i  in  DECIM_WIDTH  keep one sample every decim_i+1 cycles
- frame_len_i  in  LEN_WIDTH  words per frame
- adc_a_i  in  ADC_DATA_WIDTH  signed ADC channel A
- adc_b_i  in  ADC_DATA_WIDTH  signed ADC channel B
- dac_i  in  DAC_DATA_WIDTH  signed DAC output code
- err_i  in  16  signed PDH error signal
- data_o  out  64  packed word
- valid_o  out  1  data_o valid
- ready_i  in  1  consumer accepts word
- busy_o  out  1  high in CAPTURE or DRAIN
- done_o  out  1  frame complete
- overflow_o  out  1  sticky: at least one sample dropped this frame
- words_o  out  LEN_WIDTH  words pushed this frame

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- On reset: all outputs 0, FIFO empty, FSM in IDLE.
- Word packing: {err_i[15:0], sext16(dac_i), sext16(adc_b_i), sext16(adc_a_i)}. adc_a occupies bits [15:0]. Inputs are sign-extended to 16 bits.
- IDLE:
  - A rising edge of enable_i (registered previous value 0, current 1) latches decim_i and frame_len_i.
  - Same edge clears words_o, overflow_o and the decimation counter, then enters CAPTURE.
  - If the latched length is 0, enter DONE instead.
- CAPTURE:
  - A strobe fires on the first CAPTURE cycle, then every latched decim+1 cycles.
  - decim=0 gives a strobe every cycle.
  - On a strobe the packed word is pushed if the FIFO has room or a pop occurs in the same cycle.
  - A pushed word increments words_o.
  - Otherwise the sample is dropped: overflow_o goes to 1, words_o is not incremented, and the decimation cadence is unchanged.
  - When words_o reaches the latched length (after the push), enter DRAIN. No further strobes.
- DRAIN: when the FIFO is empty, enter DONE.
- DONE: done_o=1 and busy_o=0. Stay until enable_i=0, then go to IDLE with done_o cleared. words_o and overflow_o hold until the next arm.
- Abort: enable_i=0 in CAPTURE or DRAIN flushes the FIFO the next cycle and goes to IDLE. done_o stays 0 and overflow_o holds its value.
- Output stream:
  - First-word-fall-through; valid_o = FIFO not empty.
  - A transfer occurs when valid_o and ready_i are both high.
  - data_o and valid_o stay stable while valid_o=1 and ready_i=0.
  - Push-to-valid latency is 1 cycle: a word pushed at edge N is visible after edge N+1.
- Simultaneous push and pop:
  - On an empty FIFO, valid_o rises the next cycle and the popped word is not the new one.
  - On a full FIFO, the push is accepted.
- Decimation counter is DECIM_WIDTH wide and must not wrap incorrectly when decim is all ones (one strobe per 2^DECIM_WIDTH cycles).
- words_o saturates at the latched length.
- Changes to decim_i or frame_len_i during a frame have no effect.

Test Plan:
- Arm with decim=0, len=4, ready_i=1, ramp inputs (adc_a=1,2,3,4) -> 4 words out in order, e.g. adc_a=-1 packs as 0xFFFF in [15:0]. done_o=1 on the cycle after the FIFO empties, words_o=4, overflow_o=0.
- decim=3, len=3, ready_i=1 -> strobes at CAPTURE cycles 0, 4 and 8. Exactly 3 words; each carries the sample present at its strobe cycle.
- ready_i=0, decim=0, len=20, FIFO_DEPTH=16 -> 16 words buffered and overflow_o=1. Raise ready_i -> 16 words drain, then capture resumes until words_o=20, then done_o=1.
- Stall mid-stream (ready_i low for 5 cycles while valid_o=1) -> data_o unchanged for all 5 cycles; no word lost or duplicated.
- Deassert enable_i after 2 of 8 words -> FIFO flushed, valid_o=0 the next cycle, done_o never asserted, IDLE. Re-arm -> words_o restarts from 0.
- len=0 -> DONE directly with no words emitted. Assert rst_n=0 mid-CAPTURE -> all outputs 0 immediately, asynchronously.
